// File: rtl/serial_add_seq_pkg.sv
// rtl/serial_add_seq_pkg.sv - shared state encoding and default width for the serial adder
package serial_add_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - one-bit full-add step from two half adders and an OR
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (a),
        .y (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder, LSB first, with start/busy/done handshake
import serial_add_seq_pkg::*;

module serial_add_seq #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             step;
    logic             last;

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Sum fills from the MSB end so after WIDTH steps bit 0 holds the first computed bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                sum   <= '0;
                cout  <= 1'b0;
                cnt   <= '0;
            end else if (step) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= fa_co;
                sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                cnt   <= cnt + CW'(1);
                if (last) begin
                    cout <= fa_co;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq (WIDTH=8 and WIDTH=1)
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_seq #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: an accepted add occupies WIDTH+2 cycles and
    // its result is simply a+b+cin, published on the done cycle.
    bit          m_active = 0;
    int          m_k      = 0;
    logic [W:0]  m_full   = '0;
    logic [W-1:0] m_sum   = '0;
    logic        m_cout   = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 0;
            m_sum    = '0;
            m_cout   = 1'b0;
        end else if (m_active && cyc == m_k + W + 1) begin
            m_active = 0;
        end else if (!m_active && start) begin
            m_active = 1;
            m_k      = cyc;
            m_full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_sum    = '0;
            m_cout   = 1'b0;
        end else if (m_active && cyc == m_k + W) begin
            {m_cout, m_sum} = m_full;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_busy", busy, m_active);
            chk("model_done", done, m_active && cyc == m_k + W);
            if (!m_active || cyc == m_k + W) begin
                chk("model_sum", sum, m_sum);
                chk("model_cout", cout, m_cout);
            end
        end
    end

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input logic [W-1:0] es, input logic ec, input int eb, input string name);
        int k;
        int lat;
        int nb;
        lat = -1;
        nb  = 0;
        @(posedge clk);
        #2;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done && lat < 0) begin
                lat = cyc - k;
                chk({name, "_sum"}, sum, es);
                chk({name, "_cout"}, cout, ec);
            end
            if (!busy) break;
        end
        chk({name, "_latency"}, lat, W);
        if (eb > 0) chk({name, "_busy_cycles"}, nb, eb);
    endtask

    initial begin
        int k;
        int lat;
        int saw;
        int pulses;
        int last_d;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_busy1", busy1, 0);
        #1 rst = 1'b0;

        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 9, "ff_01");
        run_add(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 0, "5a_a5");
        run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "12_34");
        repeat (3) @(negedge clk);
        chk("hold_sum", sum, 8'h46);
        chk("hold_cout", cout, 0);

        // second start while busy must be ignored
        @(posedge clk);
        #2 a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - k;
                chk("ignore_sum", sum, 8'h10);
                chk("ignore_cout", cout, 0);
            end
        end
        chk("ignore_latency", lat, W);
        repeat (2) @(negedge clk);
        chk("ignore_idle", busy, 0);

        // reset in the middle of RUN
        @(posedge clk);
        #2 a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw++;
        end
        chk("abort_no_done", saw, 0);
        run_add(8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 9, "after_abort");

        // start held high: back-to-back adds every WIDTH+2 cycles
        @(posedge clk);
        #2 a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        pulses = 0;
        last_d = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (last_d >= 0) chk("held_interval", cyc - last_d, W + 2);
                chk("held_sum", sum, 8'h00);
                chk("held_cout", cout, 1);
                last_d = cyc;
                pulses++;
            end
        end
        chk("held_pulses", pulses >= 4, 1);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1 instance
        @(posedge clk);
        #2 a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #2 start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        chk("w1_run_busy", busy1, 1);
        chk("w1_run_done", done1, 0);
        @(negedge clk);
        chk("w1_done", done1, 1);
        chk("w1_sum", sum1, 1);
        chk("w1_cout", cout1, 1);
        @(negedge clk);
        chk("w1_idle_busy", busy1, 0);
        chk("w1_idle_done", done1, 0);
        chk("w1_hold_sum", sum1, 1);
        chk("w1_hold_cout", cout1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
